// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: control/status bundle between a run sequencer and its host.
// Host drives: start, abort, pc, instr_valid.
// Sequencer drives: cpu_reset, cpu_en, busy, done, timeout, cycle_count, retired_count, halt_pc.
interface cpu_run_ctrl_if #(parameter int CNT_W = 16, parameter int PC_W = 32);
  logic start, abort, instr_valid;
  logic [PC_W-1:0] pc;
  logic cpu_reset, cpu_en, busy, done, timeout;
  logic [CNT_W-1:0] cycle_count, retired_count;
  logic [PC_W-1:0] halt_pc;
  modport master(output start, abort, pc, instr_valid,
                 input cpu_reset, cpu_en, busy, done, timeout, cycle_count, retired_count, halt_pc);
  modport slave(input start, abort, pc, instr_valid,
                output cpu_reset, cpu_en, busy, done, timeout, cycle_count, retired_count, halt_pc);
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: holds the core in reset, runs it until a self-loop halt or cycle budget, reports counts.
// Ports: clock (rising edge), reset (async, active-low), bus (cpu_run_ctrl_if.slave):
//   in  start, abort, pc, instr_valid; out cpu_reset, cpu_en, busy, done, timeout,
//   cycle_count, retired_count (saturating), halt_pc.
module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES = 100,
  parameter int HALT_REPEAT = 3,
  parameter int CNT_W = 16,
  parameter int PC_W = 32
) (
  input logic clock,
  input logic reset,
  cpu_run_ctrl_if.slave bus
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HALT_REPEAT + 1);
  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] same_cnt, same_nx;
  logic [PC_W-1:0] last_pc;
  logic last_vld, halt, expire, clear;
  logic [CNT_W-1:0] cyc_nx;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    same_nx = (last_vld && bus.pc == last_pc) ? same_cnt + 1'b1 : '0;
    halt = state == RUN && bus.instr_valid && same_nx == SW'(HALT_REPEAT - 1);
    cyc_nx = bus.cycle_count + 1'b1;
    expire = state == RUN && cyc_nx == CNT_W'(MAX_CYCLES);
    state_nx = bus.abort ? IDLE :
               (state == IDLE || state == DONE) ? (bus.start ? HOLD : state) :
               state == HOLD ? (hold_cnt == HW'(RESET_CYCLES - 1) ? RUN : HOLD) :
               (halt || expire) ? DONE : RUN;
    // run results are wiped when going idle or when a new run begins
    clear = state_nx == IDLE || (state_nx == HOLD && state != HOLD);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bus.cpu_reset <= 1'b1;
      bus.cpu_en <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.timeout <= 1'b0;
      bus.cycle_count <= '0;
      bus.retired_count <= '0;
      bus.halt_pc <= '0;
      hold_cnt <= '0;
      same_cnt <= '0;
      last_pc <= '0;
      last_vld <= 1'b0;
    end else begin
      bus.cpu_reset <= state_nx == IDLE || state_nx == HOLD;
      bus.cpu_en <= state_nx == RUN;
      bus.busy <= state_nx == HOLD || state_nx == RUN;
      bus.done <= state_nx == DONE;
      hold_cnt <= state == HOLD ? hold_cnt + 1'b1 : '0;
      if (clear) begin
        bus.timeout <= 1'b0;
        bus.cycle_count <= '0;
        bus.retired_count <= '0;
        bus.halt_pc <= '0;
        same_cnt <= '0;
        last_pc <= '0;
        last_vld <= 1'b0;
      end else if (state == RUN) begin
        bus.cycle_count <= cyc_nx;
        if (bus.instr_valid) begin
          bus.retired_count <= &bus.retired_count ? bus.retired_count : bus.retired_count + 1'b1;
          same_cnt <= same_nx;
          last_pc <= bus.pc;
          last_vld <= 1'b1;
        end
        if (halt) bus.halt_pc <= bus.pc;
        else if (expire) bus.timeout <= 1'b1;
      end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized scoreboard bench for cpu_run_ctrl against a run-level reference model.
module tb_cpu_run_ctrl;
  localparam int RC = 4, MC = 10, HR = 3;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;
  cpu_run_ctrl_if #(.CNT_W(16), .PC_W(32)) bus();
  cpu_run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(MC), .HALT_REPEAT(HR), .CNT_W(16), .PC_W(32))
    dut (.clock(clock), .reset(reset), .bus(bus.slave));
  typedef struct packed {
    logic to;
    logic [31:0] hpc;
    logic [15:0] cc;
    logic [15:0] rc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int cmp = 0, err = 0;
  logic v_arr[MC];
  logic [31:0] p_arr[MC];
  logic done_q = 1'b0;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    cmp++;
    if (act !== req) begin
      err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // Run-level model: halt once the last HR valid PCs are identical, else stop at the budget.
  function automatic exp_t model();
    logic [31:0] seen[$];
    int ret = 0;
    bit same;
    for (int i = 0; i < MC; i++) begin
      if (v_arr[i]) begin
        ret++;
        seen.push_back(p_arr[i]);
        if (seen.size() >= HR) begin
          same = 1;
          for (int k = 1; k < HR; k++) if (seen[seen.size() - 1 - k] != p_arr[i]) same = 0;
          if (same) return '{to: 1'b0, hpc: p_arr[i], cc: 16'(i + 1), rc: 16'(ret)};
        end
      end
    end
    return '{to: 1'b1, hpc: 32'h0, cc: 16'(MC), rc: 16'(ret)};
  endfunction
  always @(negedge clock) begin
    if (bus.done && !done_q) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("result", {bus.timeout, bus.halt_pc, bus.cycle_count, bus.retired_count}, mon_e);
        chk("done_frozen", {bus.cpu_reset, bus.cpu_en, bus.busy}, 3'b000);
      end
    end
    done_q = bus.done;
  end
  task automatic check_reset_vals(input string name);
    chk(name, {bus.cpu_reset, bus.cpu_en, bus.busy, bus.done, bus.timeout,
               bus.cycle_count, bus.retired_count, bus.halt_pc}, {5'b10000, 64'h0});
  endtask
  // mode 0: normal run, 1: abort at stop_at, 2: async reset at stop_at
  task automatic run(input int mode, input int stop_at);
    int n = 0;
    if (mode == 0) sb.push_back(model());
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("restart_clear", {bus.done, bus.timeout, bus.cycle_count, bus.retired_count, bus.halt_pc}, '0);
    while (!bus.cpu_en && n < 20) begin
      if (bus.cpu_reset && bus.busy) n++;
      @(negedge clock);
    end
    chk("hold_len", n, RC);
    for (int i = 0; i < MC + 3 && !bus.done; i++) begin
      if (mode != 0 && i == stop_at) begin
        if (mode == 1) begin
          bus.abort = 1'b1;
          @(negedge clock);
          bus.abort = 1'b0;
          chk("abort_idle", {bus.cpu_reset, bus.cpu_en, bus.busy, bus.done, bus.cycle_count}, {4'b1000, 16'h0});
        end else begin
          #2 reset = 1'b0;
          #1 check_reset_vals("async_reset");
          @(negedge clock);
          reset = 1'b1;
        end
        bus.start = 1'b0;
        bus.instr_valid = 1'b0;
        @(negedge clock);
        return;
      end
      bus.instr_valid = i < MC ? v_arr[i] : 1'b0;
      bus.pc = i < MC ? p_arr[i] : 32'h0;
      bus.start = i == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
    end
    bus.start = 1'b0;
    bus.instr_valid = 1'b0;
    if (!bus.done) chk("run_finished", 0, 1);
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask
  task automatic distinct_pcs();
    for (int i = 0; i < MC; i++) begin
      v_arr[i] = 1'b1;
      p_arr[i] = 32'(4 * i);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.instr_valid = 1'b0;
    bus.pc = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("reset_state");
    distinct_pcs();
    p_arr[4] = 32'hC;
    p_arr[5] = 32'hC;
    run(0, 0);
    distinct_pcs();
    run(0, 0);
    distinct_pcs();
    p_arr[8] = 32'h1C;
    p_arr[9] = 32'h1C;
    run(0, 0);
    distinct_pcs();
    p_arr[0] = 32'hC;
    v_arr[1] = 1'b0;
    p_arr[1] = 32'h50;
    p_arr[2] = 32'hC;
    p_arr[3] = 32'hC;
    run(0, 0);
    distinct_pcs();
    run(1, 3);
    distinct_pcs();
    run(2, 5);
    for (int r = 0; r < 40; r++) begin
      int mode = $urandom_range(0, 9) < 8 ? 0 : int'($urandom_range(1, 2));
      if (mode == 0)
        for (int i = 0; i < MC; i++) begin
          v_arr[i] = $urandom_range(0, 3) != 0;
          p_arr[i] = 32'($urandom_range(0, 2) * 4);
        end
      else distinct_pcs();
      run(mode, $urandom_range(0, MC - 1));
    end
    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
